div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the RV32M `div`/`divu`/`rem`/`remu` instructions, sitting in the execute stage beside the ALU adder. It accepts one operation at a time over a valid/ready handshake and computes one quotient bit per cycle by restoring shift-subtract. The result is returned over a second valid/ready handshake to the same write-back mux that consumes the adder's `result`. Divide-by-zero and signed overflow complete in one cycle with RISC-V-mandated values.

## Interface
- `XLEN`, 32, operand and result width; only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous abort of any in-flight operation (pipeline redirect).
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high only in IDLE.
- `op`  in  2  operation select: 00 div (signed quotient), 01 divu, 10 rem (signed remainder), 11 remu.
- `a`  in  XLEN  dividend.
- `b`  in  XLEN  divisor.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  XLEN  quotient or remainder per `op`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. On `in_valid`:
  - if `b`==0, go to DONE. Quotient is 0xFFFFFFFF; remainder is `a`.
  - else if signed op, `a`==0x80000000 and `b`==0xFFFFFFFF, go to DONE. Quotient is 0x80000000; remainder is 0.
  - else latch |a| and |b| for signed ops (raw values for unsigned), plus the quotient-negate flag (a[31]^b[31]) and remainder-negate flag (a[31]). Clear the remainder register and counter, then go to CALC.
- CALC, per cycle:
  - `rs` = {rem[30:0], dvd[31]}.
  - `diff` = {1'b0,rs} − {1'b0,dvs}, 33 bits.
  - if diff[32]==0: rem←diff[31:0] and shift 1 into the quotient LSB.
  - else: rem←rs and shift in 0.
  - dvd shifts left one position, with quotient bits occupying the vacated LSBs.
  - After the 32nd iteration, go to DONE. The sign fix is applied when `result` is registered: two's-complement negate the quotient or remainder if its flag is set.
- DONE: `out_valid`=1 and `result` is held stable. When `out_ready`=1, go to IDLE. There is no same-cycle accept of a new request.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- `flush` or `rst` in any state: next state is IDLE, `out_valid`=0, and any partial result is discarded. `rst` has priority over `flush`. Both have priority over all handshakes.
- A request arriving while not in IDLE is not accepted; the upstream stage must hold it.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `result`=0
  - internal registers 0
- `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from `in_valid` or `out_ready`.
- Normal latency: an accept edge E0 enters CALC. Iterations occur on edges E1..E32, and `out_valid` is high from the cycle after E32. `out_valid` therefore rises 33 cycles after acceptance.
- Special-case latency: `out_valid` is high in the cycle immediately after the accept edge.
- After the result handshake edge, `in_ready` is high in the following cycle. Minimum request spacing is 34 cycles (normal) or 2 cycles (special).
- A flush asserted in the same cycle as an `in_valid`/`in_ready` handshake cancels that request; the block stays in IDLE.
- A flush in DONE with `out_ready`=1 drops the result. The consumer must ignore it, since the flush outranks the handshake.

## Test plan
- divu a=100, b=7 → result 14 with `out_valid` 33 cycles after acceptance; remu on the same operands → 2.
- div a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD (−3); rem → 0xFFFFFFFF (−1); rem a=7, b=0xFFFFFFFE → 1.
- Divide by zero: div a=5, b=0 → 0xFFFFFFFF; remu a=5, b=0 → 5; `out_valid` one cycle after acceptance.
- Overflow: div 0x80000000 / 0xFFFFFFFF → 0x80000000 and rem → 0, both at one-cycle latency; divu on the same operands → 0 after 33 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `result` unchanged, `in_ready`=0 and `in_valid` ignored throughout; release → IDLE next cycle.
- Flush and reset: pulse `flush` at CALC cycle 10 → `out_valid` never rises and `in_ready`=1 next cycle; a fresh divu 0xFFFFFFFF/1 then yields 0xFFFFFFFF. Repeat the scenario with `rst` in place of `flush` and check that all outputs return to their reset values.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M div/divu/rem/remu.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state, state_next;

  logic [XLEN-1:0]   dvd;       // dividend shifting out MSB-first, quotient filling LSBs
  logic [XLEN-1:0]   dvs;       // divisor magnitude
  logic [XLEN-2:0]   rem;       // partial remainder; its MSB is never needed for the next shift
  logic [CNT_W-1:0]  cnt;
  logic              neg_q;
  logic              neg_r;
  logic              want_rem;

  logic              is_signed;
  logic              div_zero;
  logic              overflow;
  logic              special;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN-1:0]   rs;
  logic [XLEN:0]     diff;
  logic              qbit;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic              last;

  // Operand classification and one shift-subtract step.
  always_comb begin
    is_signed = ~op[0];
    div_zero  = (b == '0);
    overflow  = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special   = div_zero || overflow;
    abs_a     = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    abs_b     = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    rs        = {rem, dvd[XLEN-1]};
    diff      = {1'b0, rs} - {1'b0, dvs};
    qbit      = ~diff[XLEN];
    rem_next  = qbit ? diff[XLEN-1:0] : rs;
    quo_next  = {dvd[XLEN-2:0], qbit};
    quo_fix   = neg_q ? (~quo_next + 1'b1) : quo_next;
    rem_fix   = neg_r ? (~rem_next + 1'b1) : rem_next;
    last      = (cnt == CNT_W'(XLEN-1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and handshake outputs (outputs depend on state only).
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_next = special ? DONE : CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: operand latch, iteration, and sign-corrected result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
      result   <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (div_zero) begin
              result <= op[1] ? a : '1;
            end else if (overflow) begin
              result <= op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
              dvd      <= abs_a;
              dvs      <= abs_b;
              rem      <= '0;
              cnt      <= '0;
              neg_q    <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
              neg_r    <= is_signed && a[XLEN-1];
              want_rem <= op[1];
            end
          end
        end
        CALC: begin
          rem <= rem_next[XLEN-2:0];
          dvd <= quo_next;
          cnt <= cnt + 1'b1;
          if (last) result <= want_rem ? rem_fix : quo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, random operands, backpressure, flush and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference semantics of the RV32M divide family.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'd0:    return $signed(x) / $signed(y);
      2'd1:    return x / y;
      2'd2:    return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  // Issue one operation, measure latency, optionally stall in DONE, then consume.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp,
                       input int exp_lat, input int hold);
    int lat;
    logic [31:0] want;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 60);
    check_eq({tag, "_latency"}, lat, exp_lat);
    want = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 32'hDEAD_BEEF; b = 32'h0;
      check_eq({tag, "_hold_result"}, result, want);
      check_eq({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      check_eq({tag, "_hold_out_valid"}, {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq({tag, "_result"}, result, want);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_idle_in_ready"}, {31'b0, in_ready}, 32'd1);
    check_eq({tag, "_idle_out_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  // Count out_valid cycles over a window where no result may appear.
  task automatic watch_quiet(input string tag);
    int seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq({tag, "_no_out_valid"}, seen, 32'd0);
  endtask

  // Start a long divide, abort it at CALC iteration 10 via flush or rst.
  task automatic abort_op(input string tag, input bit use_rst);
    @(negedge clk);
    op = 2'd1; a = 32'h1234_5678; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check_eq({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    if (use_rst) check_eq({tag, "_result_reset"}, result, 32'h0);
    watch_quiet(tag);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("reset_result", result, 32'h0);
    rst = 1'b0;

    do_op("divu_100_7",  2'd1, 32'd100, 32'd7, 32'd14, 33, 0);
    do_op("remu_100_7",  2'd3, 32'd100, 32'd7, 32'd2, 33, 0);
    do_op("div_m7_2",    2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    do_op("rem_m7_2",    2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    do_op("rem_7_m2",    2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    do_op("div_5_0",     2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("remu_5_0",    2'd3, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op("div_ovf",     2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op("rem_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    do_op("divu_ovfops", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 0);
    do_op("backpressure", 2'd1, 32'd1000, 32'd9, 32'd111, 33, 10);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
      if (rb == 32'h0) rb = 32'd13;
      do_op("random", ro, ra, rb, model(ro, ra, rb), 33, 0);
    end

    // Flush coinciding with an accept cancels the request.
    @(negedge clk);
    op = 2'd0; a = 32'd5; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("flush_accept_in_ready", {31'b0, in_ready}, 32'd1);
    watch_quiet("flush_accept");

    abort_op("flush_calc", 1'b0);
    do_op("after_flush", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);
    abort_op("rst_calc", 1'b1);
    do_op("after_rst", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
